// File: rtl/shifter_stage_pkg.sv
// Shared datapath definitions for the shifter stage.
//   NBITS      : datapath width
//   SHIFT_BYTE : shift distance of the byte-left shift
//   shift_op_t : microinstruction shift operation encoding
//   occ_state_t: output buffer occupancy (doubles as the buffer state)
package shifter_stage_pkg;

  localparam int unsigned NBITS      = 32;
  localparam int unsigned SHIFT_BYTE = 8;

  typedef enum logic [1:0] {
    SH_NONE = 2'd0,
    SH_SLL8 = 2'd1,
    SH_SRA1 = 2'd2,
    SH_SRL1 = 2'd3
  } shift_op_t;

  // Encoding equals the number of buffered entries.
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } occ_state_t;

endpackage

// File: rtl/shifter_stage_shifter.sv
// Combinational shifter applied to the ALU result.
//   a  : operand
//   op : shift operation (shift_op_t)
//   y  : shifted result
module shifter
  import shifter_stage_pkg::*;
#(
  parameter int unsigned NBITS = shifter_stage_pkg::NBITS
) (
  input  logic [NBITS-1:0] a,
  input  shift_op_t        op,
  output logic [NBITS-1:0] y
);

  always_comb begin
    y = a;
    unique case (op)
      SH_NONE: y = a;
      SH_SLL8: y = {a[NBITS-SHIFT_BYTE-1:0], {SHIFT_BYTE{1'b0}}};
      SH_SRA1: y = {a[NBITS-1], a[NBITS-1:1]};
      SH_SRL1: y = {1'b0, a[NBITS-1:1]};
      default: y = a;
    endcase
  end

endmodule

// File: rtl/shifter_stage.sv
// Registered shift-and-flags stage between the ALU and C-bus writeback.
// Shifts the ALU result, derives N/Z/C from the unshifted result and holds
// the outcome in a 2-entry FIFO with a valid/ready handshake on both sides.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : upstream handshake (push on in_valid & in_ready)
//   alu_y, alu_c_out     : ALU result and carry
//   sh_op                : shift operation
//   out_valid / out_ready: downstream handshake (pop on out_valid & out_ready)
//   out_y, out_n/z/c     : head entry result and flags
module shifter_stage
  import shifter_stage_pkg::*;
#(
  parameter int unsigned NBITS = shifter_stage_pkg::NBITS,
  parameter int unsigned DEPTH = 2  // only 2 is supported
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NBITS-1:0] alu_y,
  input  logic             alu_c_out,
  input  shift_op_t        sh_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NBITS-1:0] out_y,
  output logic             out_n,
  output logic             out_z,
  output logic             out_c
);

  typedef struct packed {
    logic [NBITS-1:0] y;
    logic             n;
    logic             z;
    logic             c;
  } entry_t;

  entry_t     mem_q [DEPTH];
  occ_state_t count_q, count_d;
  logic       wr_ptr_q, rd_ptr_q;
  logic       push, pop;
  logic [NBITS-1:0] sh_y;
  entry_t     in_entry, head;

  shifter #(
    .NBITS(NBITS)
  ) u_shifter (
    .a (alu_y),
    .op(sh_op),
    .y (sh_y)
  );

  // Flags come from the unshifted ALU result.
  assign in_entry = '{y: sh_y, n: alu_y[NBITS-1], z: (alu_y == '0), c: alu_c_out};

  // Both handshake outputs depend on registered occupancy only.
  assign in_ready  = (count_q != StFull);
  assign out_valid = (count_q != StEmpty);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    count_d = count_q;
    unique case (count_q)
      StEmpty: if (push) count_d = StOne;
      StOne: begin
        if (push && !pop)      count_d = StFull;
        else if (pop && !push) count_d = StEmpty;
      end
      StFull:  if (pop) count_d = StOne;
      default: count_d = StEmpty;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= StEmpty;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      if (push) begin
        mem_q[wr_ptr_q] <= in_entry;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

  // Head shows the read-pointer slot even when empty (zero after reset).
  assign head  = mem_q[rd_ptr_q];
  assign out_y = head.y;
  assign out_n = head.n;
  assign out_z = head.z;
  assign out_c = head.c;

endmodule

// File: tb/tb_shifter_stage.sv
module tb_shifter_stage;
  import shifter_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] alu_y;
  logic        alu_c_out;
  shift_op_t   sh_op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_y;
  logic        out_n;
  logic        out_z;
  logic        out_c;

  always #5 clk = ~clk;

  shifter_stage #(
    .NBITS(32),
    .DEPTH(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .alu_y    (alu_y),
    .alu_c_out(alu_c_out),
    .sh_op    (sh_op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_y    (out_y),
    .out_n    (out_n),
    .out_z    (out_z),
    .out_c    (out_c)
  );

  typedef struct packed {
    logic [31:0] y;
    logic        n;
    logic        z;
    logic        c;
  } exp_t;

  typedef struct {
    logic [31:0] y;
    logic        c;
    shift_op_t   op;
    exp_t        e;
  } vec_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_pops   = 0;
  bit   rand_done;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] y, input logic c, input shift_op_t op);
    exp_t e;
    case (op)
      SH_NONE: e.y = y;
      SH_SLL8: e.y = {y[23:0], 8'h00};
      SH_SRA1: e.y = {y[31], y[31:1]};
      default: e.y = {1'b0, y[31:1]};
    endcase
    e.n = y[31];
    e.z = (y == 32'h0);
    e.c = c;
    return e;
  endfunction

  // Scoreboard consumer: compare head against the oldest expectation on every pop.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb_q.delete();
    end else if (out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_underflow: actual=pop expected=no_pop");
      end else begin
        e = sb_q.pop_front();
        check("sb_pop", {29'h0, out_y, out_n, out_z, out_c}, {29'h0, e});
      end
      n_pops++;
    end
  end

  // Present one word and hold it until accepted; entered/left at posedge+1.
  task automatic push(input logic [31:0] y, input logic c, input shift_op_t op, input exp_t e);
    int t = 0;
    in_valid  = 1'b1;
    alu_y     = y;
    alu_c_out = c;
    sh_op     = op;
    @(negedge clk);
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL push_timeout: actual=in_ready_low expected=accept");
    end else begin
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[7];

  initial begin
    int p0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    alu_y     = '0;
    alu_c_out = 1'b0;
    sh_op     = SH_NONE;
    out_ready = 1'b0;

    vecs[0] = '{32'h0000AAAA, 1'b0, SH_SLL8, '{32'h00AAAA00, 1'b0, 1'b0, 1'b0}};
    vecs[1] = '{32'hBBBB0000, 1'b0, SH_SRA1, '{32'hDDDD8000, 1'b1, 1'b0, 1'b0}};
    vecs[2] = '{32'h80000001, 1'b0, SH_SRL1, '{32'h40000000, 1'b1, 1'b0, 1'b0}};
    vecs[3] = '{32'h00000000, 1'b1, SH_NONE, '{32'h00000000, 1'b0, 1'b1, 1'b1}};
    vecs[4] = '{32'hFF000000, 1'b1, SH_SLL8, '{32'h00000000, 1'b1, 1'b0, 1'b1}};
    vecs[5] = '{32'h7FFFFFFF, 1'b0, SH_SRA1, '{32'h3FFFFFFF, 1'b0, 1'b0, 1'b0}};
    vecs[6] = '{32'hFFFFFFFF, 1'b1, SH_SRL1, '{32'h7FFFFFFF, 1'b1, 1'b0, 1'b1}};

    repeat (2) step();
    rst = 1'b0;
    check("reset_out_valid", {63'h0, out_valid}, 64'd0);
    check("reset_in_ready", {63'h0, in_ready}, 64'd1);
    check("reset_out_y", {32'h0, out_y}, 64'd0);
    check("reset_flags", {61'h0, out_n, out_z, out_c}, 64'd0);

    // Table vectors with free-flowing output; each must be visible right after its push edge.
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      push(vecs[i].y, vecs[i].c, vecs[i].op, vecs[i].e);
      check("latency_valid", {63'h0, out_valid}, 64'd1);
      check("latency_y", {32'h0, out_y}, {32'h0, vecs[i].e.y});
    end
    step();
    check("drained_valid", {63'h0, out_valid}, 64'd0);

    // Backpressure: fill, stall a third word, then drain with a pop at count 2.
    out_ready = 1'b0;
    push(32'h1, 1'b0, SH_NONE, model(32'h1, 1'b0, SH_NONE));
    push(32'h2, 1'b0, SH_NONE, model(32'h2, 1'b0, SH_NONE));
    check("full_in_ready", {63'h0, in_ready}, 64'd0);
    p0 = n_pops;
    fork
      push(32'h3, 1'b0, SH_NONE, model(32'h3, 1'b0, SH_NONE));
      begin
        repeat (3) begin
          step();
          check("stall_in_ready", {63'h0, in_ready}, 64'd0);
          check("stall_out_y", {32'h0, out_y}, 64'h1);
        end
        out_ready = 1'b1;
        step();  // pop at count 2 must not admit the held word
        check("popfull_in_ready", {63'h0, in_ready}, 64'd1);
        check("popfull_out_y", {32'h0, out_y}, 64'h2);
        step();  // pop of 2 and push of 3 together
        check("pushpop_valid", {63'h0, out_valid}, 64'd1);
        check("pushpop_out_y", {32'h0, out_y}, 64'h3);
        step();
        check("drain_empty", {63'h0, out_valid}, 64'd0);
      end
    join
    check("drain_pops", 64'(n_pops - p0), 64'd3);

    // Reset mid-operation with a push and pop presented during the reset cycle.
    out_ready = 1'b0;
    push(32'hA, 1'b0, SH_NONE, model(32'hA, 1'b0, SH_NONE));
    push(32'hB, 1'b0, SH_NONE, model(32'hB, 1'b0, SH_NONE));
    rst       = 1'b1;
    in_valid  = 1'b1;
    alu_y     = 32'hC;
    out_ready = 1'b1;
    step();
    rst      = 1'b0;
    in_valid = 1'b0;
    check("midrst_out_valid", {63'h0, out_valid}, 64'd0);
    check("midrst_in_ready", {63'h0, in_ready}, 64'd1);
    check("midrst_out_y", {32'h0, out_y}, 64'd0);
    p0 = n_pops;
    push(32'h5, 1'b0, SH_NONE, model(32'h5, 1'b0, SH_NONE));
    repeat (3) step();
    check("midrst_single_pop", 64'(n_pops - p0), 64'd1);

    // Random traffic against the model with random backpressure.
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          logic [31:0] ry;
          logic        rc;
          shift_op_t   rop;
          ry  = $urandom();
          if (i % 8 == 0) ry = 32'h0;
          rc  = 1'($urandom_range(0, 1));
          rop = shift_op_t'($urandom_range(0, 3));
          push(ry, rc, rop, model(ry, rc, rop));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          step();
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    for (int t = 0; t < 20 && sb_q.size() != 0; t++) step();
    step();
    check("final_sb_empty", 64'(sb_q.size()), 64'd0);
    check("final_out_valid", {63'h0, out_valid}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
